// File: rtl/alu_op_sequencer_pkg.sv
// Shared definitions for alu_op_sequencer: opcodes, per-op slice select table, FSM states, idle drive.
// The MUL opcode is only legal when ALU_MUL_EN is defined.
package alu_op_sequencer_pkg;

    localparam logic [3:0] OP_ADD   = 4'd0;
    localparam logic [3:0] OP_SUB   = 4'd1;
    localparam logic [3:0] OP_AND   = 4'd2;
    localparam logic [3:0] OP_OR    = 4'd3;
    localparam logic [3:0] OP_XOR   = 4'd4;
    localparam logic [3:0] OP_NOTA  = 4'd5;
    localparam logic [3:0] OP_PASSA = 4'd6;
    localparam logic [3:0] OP_CMP   = 4'd7;
    localparam logic [3:0] OP_MUL   = 4'd8;

    // Safe drive while idle or in reset: both operands read as zero, logic mode, no carry.
    localparam logic [7:0] ALU_IDLE_AB_BAR = 8'hFF;
    localparam logic [3:0] ALU_IDLE_S      = 4'b0000;
    localparam logic       ALU_IDLE_M      = 1'b1;
    localparam logic       ALU_IDLE_CI     = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_MSTEP = 2'd2,
        ST_DONE  = 2'd3
    } seq_state_t;

    typedef struct packed {
        logic [3:0] s;
        logic       m;
        logic       ci;
    } alu_enc_t;

    // CI is the active-low carry pin: SUB drives 0 so the slice forms A + ~B + 1.
    function automatic alu_enc_t op_encoding(input logic [3:0] op);
        alu_enc_t enc;
        enc = '{s: ALU_IDLE_S, m: ALU_IDLE_M, ci: ALU_IDLE_CI};
        case (op)
            OP_ADD:   enc = '{s: 4'b1001, m: 1'b0, ci: 1'b1};
            OP_SUB:   enc = '{s: 4'b0110, m: 1'b0, ci: 1'b0};
            OP_AND:   enc = '{s: 4'b1011, m: 1'b1, ci: 1'b1};
            OP_OR:    enc = '{s: 4'b1110, m: 1'b1, ci: 1'b1};
            OP_XOR:   enc = '{s: 4'b0110, m: 1'b1, ci: 1'b1};
            OP_NOTA:  enc = '{s: 4'b0000, m: 1'b1, ci: 1'b1};
            OP_PASSA: enc = '{s: 4'b1111, m: 1'b1, ci: 1'b1};
            OP_CMP:   enc = '{s: 4'b0110, m: 1'b0, ci: 1'b1};
            OP_MUL:   enc = '{s: 4'b1001, m: 1'b0, ci: 1'b1};
            default:  enc = '{s: ALU_IDLE_S, m: ALU_IDLE_M, ci: ALU_IDLE_CI};
        endcase
        return enc;
    endfunction

    function automatic logic op_is_legal(input logic [3:0] op);
`ifdef ALU_MUL_EN
        return (op <= OP_MUL);
`else
        return (op <= OP_CMP);
`endif
    endfunction

endpackage

// File: rtl/alu_op_sequencer_mul_datapath.sv
// Product/shift register and iteration down-counter for the shift-and-add multiply.
// Only compiled when ALU_MUL_EN is defined.
`ifdef ALU_MUL_EN
module alu_seq_mul_datapath (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        load_i,
    input  logic        step_i,
    input  logic [7:0]  b_i,
    input  logic [7:0]  sum_i,
    input  logic        carry_i,
    output logic [15:0] prod_o,
    output logic [15:0] prod_next_o,
    output logic        last_o
);
    logic [15:0] p_q;
    logic [2:0]  iter_q;

    // Multiplier bit set: the slices have just produced P[15:8] + A.
    always_comb begin
        prod_next_o = p_q[0] ? {carry_i, sum_i, p_q[7:1]} : {1'b0, p_q[15:1]};
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            p_q    <= 16'h0000;
            iter_q <= 3'd0;
        end else if (load_i) begin
            p_q    <= {8'h00, b_i};
            iter_q <= 3'd7;
        end else if (step_i) begin
            p_q    <= prod_next_o;
            iter_q <= iter_q - 3'd1;
        end
    end

    assign prod_o = p_q;
    assign last_o = (iter_q == 3'd0);

endmodule
`endif

// File: rtl/alu_op_sequencer.sv
// Issuing-side sequencer for two cascaded active-low 4-bit ALU slices (operands/result inverted at the pins).
// Define ALU_MUL_EN to add the multi-cycle 8x8 shift-and-add multiply (opcode 8).
module alu_op_sequencer
    import alu_op_sequencer_pkg::*;
#(
    parameter int SETTLE_CYC = 1
) (
    input  logic       CLK,
    input  logic       RESET_BAR,
    input  logic       REQ_VALID,
    output logic       REQ_READY,
    input  logic [3:0] REQ_OP,
    input  logic [7:0] REQ_A,
    input  logic [7:0] REQ_B,
    output logic [7:0] ALU_A_BAR,
    output logic [7:0] ALU_B_BAR,
    output logic [3:0] ALU_S,
    output logic       ALU_M,
    output logic       ALU_CI,
    input  logic [7:0] ALU_F_BAR,
    input  logic       ALU_CO,
    input  logic       ALU_AEQB,
    output logic       RES_VALID,
    input  logic       RES_READY,
    output logic [7:0] RES_DATA,
    output logic [7:0] RES_HI,
    output logic       RES_Z,
    output logic       RES_C,
    output logic       RES_EQ,
    output logic       RES_ERR
);
    localparam logic [2:0] SETTLE_LD = 3'(SETTLE_CYC);

    seq_state_t state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic [3:0] op_q, op_d;
    logic [7:0] alu_a_bar_q, alu_a_bar_d;
    logic [7:0] alu_b_bar_q, alu_b_bar_d;
    logic [3:0] alu_s_q, alu_s_d;
    logic       alu_m_q, alu_m_d;
    logic       alu_ci_q, alu_ci_d;
    logic       req_ready_q, req_ready_d;
    logic       res_valid_q, res_valid_d;
    logic [7:0] res_data_q, res_data_d;
    logic       res_z_q, res_z_d;
    logic       res_c_q, res_c_d;
    logic       res_eq_q, res_eq_d;
    logic       res_err_q, res_err_d;

    alu_enc_t   req_enc;
    logic [7:0] f_true;
    logic [7:0] cap_data;
    logic       accept;

    assign req_enc = op_encoding(REQ_OP);
    assign f_true  = ~ALU_F_BAR;
    assign accept  = REQ_VALID && req_ready_q && (state_q == ST_IDLE);

`ifdef ALU_MUL_EN
    logic [7:0]  res_hi_q, res_hi_d;
    logic        mul_load, mul_step, mul_last;
    logic [15:0] mul_prod, mul_prod_next;

    alu_seq_mul_datapath u_mul (
        .clk_i       (CLK),
        .rst_n_i     (RESET_BAR),
        .load_i      (mul_load),
        .step_i      (mul_step),
        .b_i         (REQ_B),
        .sum_i       (f_true),
        .carry_i     (~ALU_CO),
        .prod_o      (mul_prod),
        .prod_next_o (mul_prod_next),
        .last_o      (mul_last)
    );
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        op_d        = op_q;
        alu_a_bar_d = alu_a_bar_q;
        alu_b_bar_d = alu_b_bar_q;
        alu_s_d     = alu_s_q;
        alu_m_d     = alu_m_q;
        alu_ci_d    = alu_ci_q;
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        res_z_d     = res_z_q;
        res_c_d     = res_c_q;
        res_eq_d    = res_eq_q;
        res_err_d   = res_err_q;
        cap_data    = 8'h00;
`ifdef ALU_MUL_EN
        res_hi_d    = res_hi_q;
        mul_load    = 1'b0;
        mul_step    = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    op_d = REQ_OP;
                    if (!op_is_legal(REQ_OP)) begin
                        // Illegal ops leave the slice drive untouched and report straight away.
                        state_d     = ST_DONE;
                        res_valid_d = 1'b1;
                        res_err_d   = 1'b1;
                        res_data_d  = 8'h00;
                        res_z_d     = 1'b0;
                        res_c_d     = 1'b0;
                        res_eq_d    = 1'b0;
`ifdef ALU_MUL_EN
                        res_hi_d    = 8'h00;
`endif
                    end else begin
                        state_d     = ST_DRIVE;
                        cnt_d       = SETTLE_LD;
                        alu_a_bar_d = ~REQ_A;
                        alu_b_bar_d = ~REQ_B;
                        alu_s_d     = req_enc.s;
                        alu_m_d     = req_enc.m;
                        alu_ci_d    = req_enc.ci;
`ifdef ALU_MUL_EN
                        if (REQ_OP == OP_MUL) begin
                            mul_load    = 1'b1;
                            alu_b_bar_d = ALU_IDLE_AB_BAR;
                        end
`endif
                    end
                end
            end
            ST_DRIVE: begin
`ifdef ALU_MUL_EN
                if (op_q == OP_MUL) begin
                    state_d = ST_MSTEP;
                    cnt_d   = SETTLE_LD;
                end else
`endif
                if (cnt_q == 3'd0) begin
                    cap_data    = (op_q == OP_CMP) ? ~alu_a_bar_q : f_true;
                    res_data_d  = cap_data;
                    res_z_d     = (cap_data == 8'h00);
                    res_c_d     = (op_q == OP_ADD) ? ~ALU_CO :
                                  ((op_q == OP_SUB) || (op_q == OP_CMP)) ? ALU_CO : 1'b0;
                    res_eq_d    = (op_q == OP_CMP) && ALU_AEQB;
                    res_err_d   = 1'b0;
`ifdef ALU_MUL_EN
                    res_hi_d    = 8'h00;
`endif
                    res_valid_d = 1'b1;
                    state_d     = ST_DONE;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
`ifdef ALU_MUL_EN
            ST_MSTEP: begin
                // Every iteration takes the full settle time so multiply latency is data independent.
                if (cnt_q == 3'd0) begin
                    mul_step = 1'b1;
                    if (mul_last) begin
                        res_data_d  = mul_prod_next[7:0];
                        res_hi_d    = mul_prod_next[15:8];
                        res_z_d     = (mul_prod_next == 16'h0000);
                        res_c_d     = 1'b0;
                        res_eq_d    = 1'b0;
                        res_err_d   = 1'b0;
                        res_valid_d = 1'b1;
                        state_d     = ST_DONE;
                    end else begin
                        cnt_d = SETTLE_LD;
                    end
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
`endif
            ST_DONE: begin
                if (RES_READY) begin
                    res_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // Registered so READY stays low through reset and rises on the first edge after it.
        req_ready_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge CLK or negedge RESET_BAR) begin
        if (!RESET_BAR) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 3'd0;
            op_q        <= 4'd0;
            alu_a_bar_q <= ALU_IDLE_AB_BAR;
            alu_b_bar_q <= ALU_IDLE_AB_BAR;
            alu_s_q     <= ALU_IDLE_S;
            alu_m_q     <= ALU_IDLE_M;
            alu_ci_q    <= ALU_IDLE_CI;
            req_ready_q <= 1'b0;
            res_valid_q <= 1'b0;
            res_data_q  <= 8'h00;
            res_z_q     <= 1'b0;
            res_c_q     <= 1'b0;
            res_eq_q    <= 1'b0;
            res_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            op_q        <= op_d;
            alu_a_bar_q <= alu_a_bar_d;
            alu_b_bar_q <= alu_b_bar_d;
            alu_s_q     <= alu_s_d;
            alu_m_q     <= alu_m_d;
            alu_ci_q    <= alu_ci_d;
            req_ready_q <= req_ready_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_z_q     <= res_z_d;
            res_c_q     <= res_c_d;
            res_eq_q    <= res_eq_d;
            res_err_q   <= res_err_d;
        end
    end

`ifdef ALU_MUL_EN
    always_ff @(posedge CLK or negedge RESET_BAR) begin
        if (!RESET_BAR) res_hi_q <= 8'h00;
        else            res_hi_q <= res_hi_d;
    end

    assign RES_HI    = res_hi_q;
    assign ALU_B_BAR = (state_q == ST_MSTEP) ? ~mul_prod[15:8] : alu_b_bar_q;
`else
    assign RES_HI    = 8'h00;
    assign ALU_B_BAR = alu_b_bar_q;
`endif

    assign REQ_READY = req_ready_q;
    assign ALU_A_BAR = alu_a_bar_q;
    assign ALU_S     = alu_s_q;
    assign ALU_M     = alu_m_q;
    assign ALU_CI    = alu_ci_q;
    assign RES_VALID = res_valid_q;
    assign RES_DATA  = res_data_q;
    assign RES_Z     = res_z_q;
    assign RES_C     = res_c_q;
    assign RES_EQ    = res_eq_q;
    assign RES_ERR   = res_err_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer paired with two cascaded active-low 4-bit ALU slice models.
// Expectations follow ALU_MUL_EN the same way the design does.
module tb_alu_op_sequencer;
    localparam int SETTLE = 1;

    logic       CLK, RESET_BAR;
    logic       REQ_VALID, REQ_READY;
    logic [3:0] REQ_OP;
    logic [7:0] REQ_A, REQ_B;
    logic [7:0] ALU_A_BAR, ALU_B_BAR, ALU_F_BAR;
    logic [3:0] ALU_S;
    logic       ALU_M, ALU_CI, ALU_CO, ALU_AEQB;
    logic       RES_VALID, RES_READY;
    logic [7:0] RES_DATA, RES_HI;
    logic       RES_Z, RES_C, RES_EQ, RES_ERR;

    int errors = 0;
    int checks = 0;

    alu_op_sequencer #(.SETTLE_CYC(SETTLE)) dut (
        .CLK(CLK), .RESET_BAR(RESET_BAR),
        .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_OP(REQ_OP), .REQ_A(REQ_A), .REQ_B(REQ_B),
        .ALU_A_BAR(ALU_A_BAR), .ALU_B_BAR(ALU_B_BAR), .ALU_S(ALU_S), .ALU_M(ALU_M), .ALU_CI(ALU_CI),
        .ALU_F_BAR(ALU_F_BAR), .ALU_CO(ALU_CO), .ALU_AEQB(ALU_AEQB),
        .RES_VALID(RES_VALID), .RES_READY(RES_READY), .RES_DATA(RES_DATA), .RES_HI(RES_HI),
        .RES_Z(RES_Z), .RES_C(RES_C), .RES_EQ(RES_EQ), .RES_ERR(RES_ERR)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // One slice: functions defined on true (active-high) values, pins inverted, CI/CO active-low.
    function automatic logic [5:0] slice181(input logic [3:0] a_n, input logic [3:0] b_n,
                                            input logic [3:0] s, input logic m, input logic ci_n);
        logic [3:0] a, b, f;
        logic [4:0] sum;
        a = ~a_n;
        b = ~b_n;
        f = 4'h0;
        sum = 5'h00;
        if (m) begin
            case (s)
                4'h0: f = ~a;        4'h1: f = ~(a | b);  4'h2: f = ~a & b;    4'h3: f = 4'h0;
                4'h4: f = ~(a & b);  4'h5: f = ~b;        4'h6: f = a ^ b;     4'h7: f = a & ~b;
                4'h8: f = ~a | b;    4'h9: f = ~(a ^ b);  4'hA: f = b;         4'hB: f = a & b;
                4'hC: f = 4'hF;      4'hD: f = a | ~b;    4'hE: f = a | b;     default: f = a;
            endcase
        end else begin
            case (s)
                4'h9:    sum = {1'b0, a} + {1'b0, b} + {4'h0, ~ci_n};
                4'h6:    sum = {1'b0, a} + {1'b0, ~b} + {4'h0, ~ci_n};
                default: sum = {1'b0, a} + {4'h0, ~ci_n};
            endcase
            f = sum[3:0];
        end
        return {~f, ~sum[4], (f == 4'hF)};
    endfunction

    logic [5:0] sl_lo, sl_hi;
    always_comb begin
        sl_lo     = slice181(ALU_A_BAR[3:0], ALU_B_BAR[3:0], ALU_S, ALU_M, ALU_CI);
        sl_hi     = slice181(ALU_A_BAR[7:4], ALU_B_BAR[7:4], ALU_S, ALU_M, sl_lo[1]);
        ALU_F_BAR = {sl_hi[5:2], sl_lo[5:2]};
        ALU_CO    = sl_hi[1];
        ALU_AEQB  = sl_lo[0] & sl_hi[0];
    end

    typedef struct {
        logic [3:0] op;
        logic [7:0] a, b;
        logic [7:0] data, hi;
        logic       z, c, eq, err;
    } vec_t;

    vec_t tbl[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic add_vec(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] data, input logic [7:0] hi,
                           input logic z, input logic c, input logic eq, input logic err);
        vec_t v;
        v.op = op; v.a = a; v.b = b; v.data = data; v.hi = hi;
        v.z = z; v.c = c; v.eq = eq; v.err = err;
        tbl.push_back(v);
    endtask

    // Reference: plain arithmetic on the operands.
    function automatic vec_t ref_model(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        vec_t r;
        logic [8:0]  s9;
        logic [15:0] p;
        r.op = op; r.a = a; r.b = b;
        r.data = 8'h00; r.hi = 8'h00; r.z = 1'b0; r.c = 1'b0; r.eq = 1'b0; r.err = 1'b0;
        case (op)
            4'd0: begin s9 = {1'b0, a} + {1'b0, b}; r.data = s9[7:0]; r.c = s9[8]; end
            4'd1: begin r.data = a - b; r.c = (a < b); end
            4'd2: r.data = a & b;
            4'd3: r.data = a | b;
            4'd4: r.data = a ^ b;
            4'd5: r.data = ~a;
            4'd6: r.data = a;
            4'd7: begin r.data = a; r.c = (a <= b); r.eq = (a == b); end
`ifdef ALU_MUL_EN
            4'd8: begin
                p = {8'h00, a} * {8'h00, b};
                r.data = p[7:0];
                r.hi = p[15:8];
                r.z = (p == 16'h0000);
            end
`endif
            default: r.err = 1'b1;
        endcase
        if (!r.err && op != 4'd8) r.z = (r.data == 8'h00);
        return r;
    endfunction

    function automatic int exp_latency(input logic [3:0] op);
        if (op <= 4'd7) return SETTLE + 1;
`ifdef ALU_MUL_EN
        if (op == 4'd8) return 8 * (SETTLE + 1) + 1;
`endif
        return -1;
    endfunction

    task automatic wait_ready(input string tag);
        int n;
        n = 0;
        while (!REQ_READY && n < 100) begin
            @(negedge CLK);
            n++;
        end
        check({tag, "_req_ready"}, 32'(REQ_READY), 32'(1));
    endtask

    task automatic run_op(input vec_t v, input int hold, input string tag);
        int lat;
        int el;
        wait_ready(tag);
        REQ_OP = v.op; REQ_A = v.a; REQ_B = v.b; REQ_VALID = 1'b1;
        @(negedge CLK);
        REQ_VALID = 1'b0;
        check({tag, "_ready_drop"}, 32'(REQ_READY), 32'(0));
        lat = 0;
        while (!RES_VALID && lat < 300) begin
            @(negedge CLK);
            lat++;
        end
        check({tag, "_res_valid"}, 32'(RES_VALID), 32'(1));
        el = exp_latency(v.op);
        if (el >= 0) check({tag, "_latency"}, 32'(lat), 32'(el));
        else         check({tag, "_err_latency_le1"}, 32'(lat <= 1), 32'(1));
        check({tag, "_result"}, 32'({RES_HI, RES_DATA, RES_Z, RES_C, RES_EQ, RES_ERR}),
              32'({v.hi, v.data, v.z, v.c, v.eq, v.err}));
        for (int i = 0; i < hold; i++) begin
            @(negedge CLK);
            check($sformatf("%s_hold%0d", tag, i),
                  32'({REQ_READY, RES_VALID, RES_HI, RES_DATA, RES_Z, RES_C, RES_EQ, RES_ERR}),
                  32'({1'b0, 1'b1, v.hi, v.data, v.z, v.c, v.eq, v.err}));
        end
        RES_READY = 1'b1;
        @(negedge CLK);
        RES_READY = 1'b0;
        check({tag, "_handoff"}, 32'({RES_VALID, REQ_READY}), 32'({1'b0, 1'b1}));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        add_vec(4'd0, 8'h7F, 8'h01, 8'h80, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        add_vec(4'd0, 8'hFF, 8'h01, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0);
        add_vec(4'd1, 8'h10, 8'h20, 8'hF0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
        add_vec(4'd1, 8'h20, 8'h10, 8'h10, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        add_vec(4'd7, 8'h5A, 8'h5A, 8'h5A, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0);
        add_vec(4'd7, 8'h5A, 8'h5B, 8'h5A, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
        add_vec(4'd7, 8'h60, 8'h20, 8'h60, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        add_vec(4'd4, 8'hF0, 8'h3C, 8'hCC, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        add_vec(4'd2, 8'hF0, 8'h3C, 8'h30, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        add_vec(4'd3, 8'hF0, 8'h3C, 8'hFC, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        add_vec(4'd5, 8'h5A, 8'h00, 8'hA5, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        add_vec(4'd6, 8'h00, 8'h77, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
        add_vec(4'hC, 8'h12, 8'h34, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
        add_vec(4'hF, 8'hFF, 8'hFF, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
`ifdef ALU_MUL_EN
        add_vec(4'd8, 8'hFF, 8'hFF, 8'h01, 8'hFE, 1'b0, 1'b0, 1'b0, 1'b0);
        add_vec(4'd8, 8'h00, 8'h37, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
        add_vec(4'd8, 8'h0D, 8'h0B, 8'h8F, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
`else
        add_vec(4'd8, 8'hFF, 8'hFF, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
        add_vec(4'd8, 8'h00, 8'h37, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
`endif

        REQ_VALID = 1'b0; REQ_OP = 4'd0; REQ_A = 8'h00; REQ_B = 8'h00; RES_READY = 1'b0;
        RESET_BAR = 1'b1;
        #3 RESET_BAR = 1'b0;
        repeat (3) @(negedge CLK);
        check("reset_res", 32'({REQ_READY, RES_VALID, RES_HI, RES_DATA, RES_Z, RES_C, RES_EQ, RES_ERR}), 32'(0));
        check("reset_alu", 32'({ALU_A_BAR, ALU_B_BAR, ALU_S, ALU_M, ALU_CI}),
              32'({8'hFF, 8'hFF, 4'h0, 1'b1, 1'b1}));
        RESET_BAR = 1'b1;
        #1 check("ready_low_after_release", 32'(REQ_READY), 32'(0));
        @(negedge CLK);
        check("ready_first_edge", 32'(REQ_READY), 32'(1));

        foreach (tbl[i]) run_op(tbl[i], i % 3, $sformatf("vec%0d", i));

        v = ref_model(4'd0, 8'h7F, 8'h01);
        run_op(v, 5, "hold5");

        for (int i = 0; i < 60; i++) begin
            logic [3:0] op;
            op = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(9, 15)) : 4'($urandom_range(0, 8));
            v = ref_model(op, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
            run_op(v, $urandom_range(0, 2), $sformatf("rnd%0d_op%0d", i, op));
        end

        // Reset while an operation is in flight.
        wait_ready("midrst");
`ifdef ALU_MUL_EN
        REQ_OP = 4'd8;
`else
        REQ_OP = 4'd0;
`endif
        REQ_A = 8'h12; REQ_B = 8'h34; REQ_VALID = 1'b1;
        @(negedge CLK);
        REQ_VALID = 1'b0;
`ifdef ALU_MUL_EN
        repeat (4) @(negedge CLK);
`endif
        #2 RESET_BAR = 1'b0;
        #1;
        check("midrst_res", 32'({REQ_READY, RES_VALID, RES_HI, RES_DATA, RES_Z, RES_C, RES_EQ, RES_ERR}), 32'(0));
        check("midrst_alu", 32'({ALU_A_BAR, ALU_B_BAR, ALU_S, ALU_M, ALU_CI}),
              32'({8'hFF, 8'hFF, 4'h0, 1'b1, 1'b1}));
        @(negedge CLK);
        RESET_BAR = 1'b1;
        @(negedge CLK);
        check("midrst_ready_back", 32'(REQ_READY), 32'(1));
        run_op(tbl[0], 0, "post_reset_add");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
